// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Stall/flush controller for the five-stage pipeline (F, D, E, M, W).
//   - A per-register pending scoreboard holds decode for RAW hazards on
//     registers written by loads and long-unit ops.
//   - A latency counter blocks a second long op until the unit frees up.
//   - A fetch FSM (IDLE/WAIT/DROP) discards an instruction response that
//     belongs to a path abandoned by an accepted redirect.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   d_valid/d_wen/d_dst        decode instruction and its destination
//   d_load/d_long/d_lat        load / long-op flags and long-op latency
//   src_valid/src_addr         decode source operands (packed, AW bits each)
//   wb_valid/wb_dst            writeback ports (packed, AW bits each)
//   redirect                   mispredicted branch in E, held until accepted
//   ireq_valid/iresp_data_ok   instruction bus handshake
//   dreq_valid/dresp_data_ok   data bus handshake
//   stall_f/d/e/m              hold the stage register
//   flush_d/e/w                insert a bubble into the stage
//   fetch_drop                 discard the current instruction response
//   long_busy                  long-unit counter non-zero
//   perf_raw/struct/mem/if     stall-cycle counters
//
// Build option
//   HAZARD_PERF_EN  when defined, the four saturating perf counters are
//                   built; otherwise the perf ports are tied to zero.
module hazard_scoreboard #(
  parameter  int NREG    = 32,
  parameter  int NSRC    = 3,
  parameter  int NWB     = 2,
  parameter  int LAT_MAX = 64,
  localparam int AW      = $clog2(NREG),
  localparam int LW      = $clog2(LAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_valid,
  input  logic               d_wen,
  input  logic [AW-1:0]      d_dst,
  input  logic               d_load,
  input  logic               d_long,
  input  logic [LW-1:0]      d_lat,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic [NWB-1:0]     wb_valid,
  input  logic [NWB*AW-1:0]  wb_dst,
  input  logic               redirect,
  input  logic               ireq_valid,
  input  logic               iresp_data_ok,
  input  logic               dreq_valid,
  input  logic               dresp_data_ok,
  output logic               stall_f,
  output logic               stall_d,
  output logic               stall_e,
  output logic               stall_m,
  output logic               flush_d,
  output logic               flush_e,
  output logic               flush_w,
  output logic               fetch_drop,
  output logic               long_busy,
  output logic [31:0]        perf_raw,
  output logic [31:0]        perf_struct,
  output logic [31:0]        perf_mem,
  output logic [31:0]        perf_if
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  localparam logic [LW-1:0] CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] CNT_ZERO = {LW{1'b0}};

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_nxt_s;
  logic [NREG-1:0] wb_hit_s;
  logic [NREG-1:0] set_s;
  logic [LW-1:0]   count_r;
  logic [LW-1:0]   count_nxt_s;
  fetch_state_t    state_r;
  fetch_state_t    state_nxt_s;
  logic            raw_s;
  logic            struct_s;
  logic            mem_wait_s;
  logic            if_wait_s;
  logic            stall_d_s;
  logic            redirect_acc_s;
  logic            issue_s;
  logic            drop_s;

  // Writeback hit mask and RAW detection; a same-cycle writeback bypasses
  // through the write-through regfile, so it cancels the hazard.
  always_comb begin
    wb_hit_s = {NREG{1'b0}};
    for (int j = 0; j < NWB; j++) begin
      wb_hit_s[wb_dst[j*AW +: AW]] = wb_hit_s[wb_dst[j*AW +: AW]] | wb_valid[j];
    end
    raw_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      raw_s = raw_s | (src_valid[i] &
                       (src_addr[i*AW +: AW] != {AW{1'b0}}) &
                       pending_r[src_addr[i*AW +: AW]] &
                       ~wb_hit_s[src_addr[i*AW +: AW]]);
    end
  end

  assign mem_wait_s     = dreq_valid & ~dresp_data_ok;
  // count==1 means the unit frees this cycle, so a new long op may issue.
  assign struct_s       = d_valid & d_long & (count_r > CNT_ONE);
  assign if_wait_s      = (ireq_valid & ~iresp_data_ok) | (state_r == F_DROP);
  assign stall_d_s      = raw_s | struct_s | mem_wait_s;
  assign redirect_acc_s = redirect & ~mem_wait_s;
  // A wrong-path decode instruction must never mark a register pending.
  assign issue_s        = d_valid & ~stall_d_s & ~redirect;

  assign stall_m    = mem_wait_s;
  assign stall_e    = mem_wait_s;
  assign stall_d    = stall_d_s;
  assign stall_f    = stall_d_s | if_wait_s;
  assign flush_e    = (stall_d_s & ~mem_wait_s) | redirect_acc_s;
  assign flush_d    = (if_wait_s & ~stall_d_s) | redirect_acc_s | drop_s;
  assign flush_w    = mem_wait_s;
  assign fetch_drop = drop_s;
  assign long_busy  = (count_r != CNT_ZERO);

  // Next scoreboard and long-unit counter; set is applied after clear so
  // it wins on a same-register collision, and x0 is never pending.
  always_comb begin
    set_s        = {NREG{1'b0}};
    set_s[d_dst] = issue_s & d_wen & (d_load | d_long);
    pending_nxt_s    = (pending_r & ~wb_hit_s) | set_s;
    pending_nxt_s[0] = 1'b0;
    if (issue_s && d_long) begin
      count_nxt_s = (d_lat == CNT_ZERO) ? CNT_ONE : d_lat;
    end else if (count_r != CNT_ZERO) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Fetch FSM next state and response-discard decision.
  always_comb begin
    state_nxt_s = state_r;
    drop_s      = 1'b0;
    case (state_r)
      F_IDLE: begin
        if (ireq_valid && !iresp_data_ok) begin
          state_nxt_s = redirect_acc_s ? F_DROP : F_WAIT;
        end else begin
          state_nxt_s = F_IDLE;
        end
      end
      F_WAIT: begin
        if (iresp_data_ok) begin
          state_nxt_s = F_IDLE;
          drop_s      = redirect_acc_s;
        end else if (redirect_acc_s) begin
          state_nxt_s = F_DROP;
        end else begin
          state_nxt_s = F_WAIT;
        end
      end
      F_DROP: begin
        if (iresp_data_ok) begin
          state_nxt_s = F_IDLE;
          drop_s      = 1'b1;
        end else begin
          state_nxt_s = F_DROP;
        end
      end
      default: begin
        state_nxt_s = F_IDLE;
        drop_s      = 1'b0;
      end
    endcase
  end

  // State registers: scoreboard, long-unit counter and fetch FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= {NREG{1'b0}};
      count_r   <= CNT_ZERO;
      state_r   <= F_IDLE;
    end else begin
      pending_r <= pending_nxt_s;
      count_r   <= count_nxt_s;
      state_r   <= state_nxt_s;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_raw_r;
  logic [31:0] perf_struct_r;
  logic [31:0] perf_mem_r;
  logic [31:0] perf_if_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  // Saturating stall-cause counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_raw_r    <= 32'd0;
      perf_struct_r <= 32'd0;
      perf_mem_r    <= 32'd0;
      perf_if_r     <= 32'd0;
    end else begin
      perf_raw_r    <= sat_inc(perf_raw_r, raw_s);
      perf_struct_r <= sat_inc(perf_struct_r, struct_s);
      perf_mem_r    <= sat_inc(perf_mem_r, mem_wait_s);
      perf_if_r     <= sat_inc(perf_if_r, if_wait_s);
    end
  end

  assign perf_raw    = perf_raw_r;
  assign perf_struct = perf_struct_r;
  assign perf_mem    = perf_mem_r;
  assign perf_if     = perf_if_r;
`else
  assign perf_raw    = 32'd0;
  assign perf_struct = 32'd0;
  assign perf_mem    = 32'd0;
  assign perf_if     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vectors with literal checks,
// plus a per-cycle comparison against a behavioural model that tracks
// pending registers, remaining long-unit cycles and the outstanding fetch.
module tb_hazard_scoreboard;
  localparam int NREG    = 32;
  localparam int NSRC    = 3;
  localparam int NWB     = 2;
  localparam int LAT_MAX = 64;
  localparam int AW      = $clog2(NREG);
  localparam int LW      = $clog2(LAT_MAX + 1);
`ifdef HAZARD_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               d_valid, d_wen, d_load, d_long;
  logic [AW-1:0]      d_dst;
  logic [LW-1:0]      d_lat;
  logic [NSRC-1:0]    src_valid;
  logic [NSRC*AW-1:0] src_addr;
  logic [NWB-1:0]     wb_valid;
  logic [NWB*AW-1:0]  wb_dst;
  logic               redirect, ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
  logic               stall_f, stall_d, stall_e, stall_m;
  logic               flush_d, flush_e, flush_w, fetch_drop, long_busy;
  logic [31:0]        perf_raw, perf_struct, perf_mem, perf_if;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .NWB(NWB), .LAT_MAX(LAT_MAX)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_wen(d_wen), .d_dst(d_dst), .d_load(d_load),
    .d_long(d_long), .d_lat(d_lat),
    .src_valid(src_valid), .src_addr(src_addr),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .redirect(redirect),
    .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok),
    .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fetch_drop(fetch_drop), .long_busy(long_busy),
    .perf_raw(perf_raw), .perf_struct(perf_struct),
    .perf_mem(perf_mem), .perf_if(perf_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_pend [NREG];   // register awaits a load/long result
  int     m_left;          // cycles the long unit stays busy
  bit     m_out;           // an instruction request awaits its response
  bit     m_doom;          // that response belongs to an abandoned path
  longint m_perf [4];
  bit     e_wb [NREG];
  bit     e_raw, e_struct, e_mem, e_ifw, e_acc, e_drop, e_issue;
  bit     e_stall_d, e_flush_d, e_flush_e;

  function automatic logic [31:0] perf_exp(input int k);
    return PERF_ON ? m_perf[k][31:0] : 32'd0;
  endfunction

  task automatic compute_expect();
    for (int r = 0; r < NREG; r++) e_wb[r] = 1'b0;
    for (int j = 0; j < NWB; j++)
      if (wb_valid[j]) e_wb[wb_dst[j*AW +: AW]] = 1'b1;
    e_raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int a;
      a = int'(src_addr[i*AW +: AW]);
      if (src_valid[i] && a != 0 && m_pend[a] && !e_wb[a]) e_raw = 1'b1;
    end
    e_mem     = dreq_valid && !dresp_data_ok;
    e_struct  = d_valid && d_long && (m_left > 1);
    e_stall_d = e_raw || e_struct || e_mem;
    e_ifw     = (ireq_valid && !iresp_data_ok) || (m_out && m_doom);
    e_acc     = redirect && !e_mem;
    e_drop    = m_out && iresp_data_ok && (m_doom || e_acc);
    e_issue   = d_valid && !e_stall_d && !redirect;
    e_flush_e = (e_stall_d && !e_mem) || e_acc;
    e_flush_d = (e_ifw && !e_stall_d) || e_acc || e_drop;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    compute_expect();
    chk("cmp_stall_m", stall_m, 32'(e_mem));
    chk("cmp_stall_e", stall_e, 32'(e_mem));
    chk("cmp_stall_d", stall_d, 32'(e_stall_d));
    chk("cmp_stall_f", stall_f, 32'(e_stall_d || e_ifw));
    chk("cmp_flush_d", flush_d, 32'(e_flush_d));
    chk("cmp_flush_e", flush_e, 32'(e_flush_e));
    chk("cmp_flush_w", flush_w, 32'(e_mem));
    chk("cmp_fetch_drop", fetch_drop, 32'(e_drop));
    chk("cmp_long_busy", long_busy, 32'(m_left != 0));
    chk("cmp_perf_raw", perf_raw, perf_exp(0));
    chk("cmp_perf_struct", perf_struct, perf_exp(1));
    chk("cmp_perf_mem", perf_mem, perf_exp(2));
    chk("cmp_perf_if", perf_if, perf_exp(3));
  end

  // Model state update, using the expectations computed at the preceding negedge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) m_pend[r] <= 1'b0;
      for (int k = 0; k < 4; k++) m_perf[k] <= 64'd0;
      m_left <= 0;
      m_out  <= 1'b0;
      m_doom <= 1'b0;
    end else begin
      if (e_raw    && m_perf[0] < 64'hFFFF_FFFF) m_perf[0] <= m_perf[0] + 64'd1;
      if (e_struct && m_perf[1] < 64'hFFFF_FFFF) m_perf[1] <= m_perf[1] + 64'd1;
      if (e_mem    && m_perf[2] < 64'hFFFF_FFFF) m_perf[2] <= m_perf[2] + 64'd1;
      if (e_ifw    && m_perf[3] < 64'hFFFF_FFFF) m_perf[3] <= m_perf[3] + 64'd1;
      for (int r = 0; r < NREG; r++) if (e_wb[r]) m_pend[r] <= 1'b0;
      if (e_issue && d_wen && (d_load || d_long) && d_dst != 0) m_pend[d_dst] <= 1'b1;
      if (e_issue && d_long) m_left <= (d_lat == 0) ? 1 : int'(d_lat);
      else if (m_left > 0) m_left <= m_left - 1;
      if (!m_out) begin
        if (ireq_valid && !iresp_data_ok) begin
          m_out  <= 1'b1;
          m_doom <= e_acc;
        end
      end else if (iresp_data_ok) begin
        m_out  <= 1'b0;
        m_doom <= 1'b0;
      end else if (e_acc) begin
        m_doom <= 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    d_valid = 1'b0; d_wen = 1'b0; d_load = 1'b0; d_long = 1'b0;
    d_dst = '0; d_lat = '0; src_valid = '0; src_addr = '0;
    wb_valid = '0; wb_dst = '0; redirect = 1'b0;
    ireq_valid = 1'b0; iresp_data_ok = 1'b0; dreq_valid = 1'b0; dresp_data_ok = 1'b0;
  endtask

  task automatic set_src(input int i, input int r);
    src_valid[i] = 1'b1;
    src_addr[i*AW +: AW] = r[AW-1:0];
  endtask

  task automatic set_wb(input int j, input int r);
    wb_valid[j] = 1'b1;
    wb_dst[j*AW +: AW] = r[AW-1:0];
  endtask

  task automatic issue_op(input int dst, input bit ld, input bit lng, input int lat);
    d_valid = 1'b1; d_wen = 1'b1; d_load = ld; d_long = lng;
    d_dst = dst[AW-1:0]; d_lat = lat[LW-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall_f"}, stall_f, 32'd0);
    chk({tag, "_stall_d"}, stall_d, 32'd0);
    chk({tag, "_stall_e"}, stall_e, 32'd0);
    chk({tag, "_stall_m"}, stall_m, 32'd0);
    chk({tag, "_flush_d"}, flush_d, 32'd0);
    chk({tag, "_flush_e"}, flush_e, 32'd0);
    chk({tag, "_flush_w"}, flush_w, 32'd0);
    chk({tag, "_fetch_drop"}, fetch_drop, 32'd0);
    chk({tag, "_long_busy"}, long_busy, 32'd0);
    chk({tag, "_perf_raw"}, perf_raw, 32'd0);
    chk({tag, "_perf_struct"}, perf_struct, 32'd0);
    chk({tag, "_perf_mem"}, perf_mem, 32'd0);
    chk({tag, "_perf_if"}, perf_if, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;

    // Load to x5, then a reader stalls until the writeback cycle.
    idle(); issue_op(5, 1'b1, 1'b0, 0);
    #1 chk("load_issue_stall_d", stall_d, 32'd0);
    tick();
    idle(); d_valid = 1'b1; set_src(0, 5);
    #1 chk("raw1_stall_d", stall_d, 32'd1); chk("raw1_flush_e", flush_e, 32'd1);
    tick();
    #1 chk("raw2_stall_d", stall_d, 32'd1);
    tick();
    set_wb(0, 5);
    #1 chk("raw_wb_stall_d", stall_d, 32'd0); chk("raw_wb_flush_e", flush_e, 32'd0);
    tick();
    idle(); d_valid = 1'b1; set_src(1, 5);
    #1 chk("raw_cleared_stall_d", stall_d, 32'd0);
    tick();

    // Long op lat 4 at t; a second long op waits through t+1..t+3.
    idle(); issue_op(9, 1'b0, 1'b1, 4);
    #1 chk("long_idle_busy", long_busy, 32'd0);
    tick();
    idle(); issue_op(10, 1'b0, 1'b1, 3);
    for (int k = 1; k <= 3; k++) begin
      #1 chk("struct_stall_d", stall_d, 32'd1); chk("struct_busy", long_busy, 32'd1);
      tick();
    end
    #1 chk("long2_issue_stall_d", stall_d, 32'd0); chk("long2_issue_busy", long_busy, 32'd1);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1 chk("long2_busy", long_busy, 32'd1);
      tick();
    end
    #1 chk("long2_done_busy", long_busy, 32'd0);
    // Read x9 and x10; only x9 is written back this cycle.
    d_valid = 1'b1; set_src(0, 9); set_src(2, 10); set_wb(1, 9);
    #1 chk("long_raw_stall_d", stall_d, 32'd1);
    tick();
    wb_valid = '0; set_wb(0, 10);
    #1 chk("long_raw_bypass", stall_d, 32'd0);
    tick();

    // Set and clear on x12 in the same cycle: set wins.
    idle(); issue_op(12, 1'b1, 1'b0, 0); set_wb(1, 12);
    tick();
    idle(); d_valid = 1'b1; set_src(1, 12);
    #1 chk("set_wins_stall_d", stall_d, 32'd1);
    tick();
    idle(); set_wb(0, 12);
    tick();

    // Long op with latency 0 is busy for exactly one cycle.
    idle(); d_valid = 1'b1; d_long = 1'b1; d_lat = '0;
    tick();
    idle();
    #1 chk("lat0_busy", long_busy, 32'd1);
    tick();
    #1 chk("lat0_done", long_busy, 32'd0);

    // Load to x0 never marks pending; reading x0 never stalls.
    idle(); issue_op(0, 1'b1, 1'b0, 0);
    tick();
    idle(); d_valid = 1'b1; set_src(0, 0); set_src(1, 0); set_src(2, 0);
    #1 chk("x0_stall_d", stall_d, 32'd0);
    tick();

    // Fetch: request, redirect while waiting, response is dropped.
    idle(); ireq_valid = 1'b1;
    #1 chk("if1_stall_f", stall_f, 32'd1); chk("if1_flush_d", flush_d, 32'd1);
    tick();
    redirect = 1'b1;
    #1 chk("if2_flush_d", flush_d, 32'd1); chk("if2_flush_e", flush_e, 32'd1);
    tick();
    redirect = 1'b0;
    #1 chk("if3_stall_f", stall_f, 32'd1);
    tick();
    idle(); iresp_data_ok = 1'b1;
    #1 chk("if4_fetch_drop", fetch_drop, 32'd1); chk("if4_flush_d", flush_d, 32'd1);
    tick();
    idle();
    #1 chk("if5_fetch_drop", fetch_drop, 32'd0); chk("if5_stall_f", stall_f, 32'd0);

    // Memory wait blocks redirect acceptance until the data arrives.
    ireq_valid = 1'b1;
    tick();
    idle(); dreq_valid = 1'b1; redirect = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("mem_stall_m", stall_m, 32'd1); chk("mem_stall_e", stall_e, 32'd1);
      chk("mem_stall_d", stall_d, 32'd1); chk("mem_stall_f", stall_f, 32'd1);
      chk("mem_flush_w", flush_w, 32'd1); chk("mem_flush_d", flush_d, 32'd0);
      chk("mem_flush_e", flush_e, 32'd0);
      tick();
    end
    dresp_data_ok = 1'b1; issue_op(7, 1'b1, 1'b0, 0);
    #1 chk("mem_ok_flush_d", flush_d, 32'd1); chk("mem_ok_flush_e", flush_e, 32'd1);
    chk("mem_ok_stall_d", stall_d, 32'd0);
    tick();
    idle(); d_valid = 1'b1; set_src(0, 7);
    #1 chk("wrongpath_no_pending", stall_d, 32'd0);
    tick();
    idle(); iresp_data_ok = 1'b1;
    #1 chk("mem_drop", fetch_drop, 32'd1);
    tick();

    // Reset while in DROP with x7 pending.
    idle(); issue_op(7, 1'b1, 1'b0, 0);
    tick();
    idle(); ireq_valid = 1'b1; redirect = 1'b1;
    tick();
    idle();
    #1 chk("pre_rst_drop_stall_f", stall_f, 32'd1);
    #1 reset = 1'b1;
    #1 check_all_zero("midrst");
    tick();
    reset = 1'b0;
    d_valid = 1'b1; set_src(0, 7); iresp_data_ok = 1'b1;
    #1 chk("post_rst_stall_d", stall_d, 32'd0); chk("post_rst_fetch_drop", fetch_drop, 32'd0);
    tick();
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
